// File: rtl/mult_pkg.sv
// Shared types and helpers for the Multiplier family of blocks.
// Holds the accumulator FSM state type and the sum-width helper.
package mult_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_t;

  // Width of a sum of `count` unsigned prod_w-bit values.
  // It is sized so that the sum can never overflow.
  function automatic int acc_width(
    input int prod_w,
    input int count
  );
    return prod_w + $clog2(count);
  endfunction

endpackage

// File: rtl/multiplier.sv
// Combinational unsigned multiplier: out = a * b.
// Ports: a (WIDTH_A), b (WIDTH_B), out (WIDTH_A+WIDTH_B).
module Multiplier #(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 6
) (
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  output logic [WIDTH_A+WIDTH_B-1:0] out
);

  localparam int PW = WIDTH_A + WIDTH_B;

  assign out = PW'(a) * PW'(b);

endmodule

// File: rtl/product_accumulator.sv
// Sums each frame of COUNT products from Multiplier into one word.
// Ports: clk, rst (sync, active high), in_prod/in_valid/in_ready
// (product stream), out_sum/out_valid/out_ready (frame sums),
// clr (frame abort, present only when ACC_CLEAR_EN is defined).
module product_accumulator
  import mult_pkg::*;
#(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 6,
  parameter int COUNT   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef ACC_CLEAR_EN
  input  logic                    clr,
`endif
  input  logic [WIDTH_A+WIDTH_B-1:0] in_prod,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH_A+WIDTH_B+$clog2(COUNT)-1:0] out_sum,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int PROD_W = WIDTH_A + WIDTH_B;
  localparam int ACC_W  = acc_width(PROD_W, COUNT);
  localparam int CNT_W  = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  acc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W-1:0] nxt;
  logic             accept;

  assign in_ready  = (state_q == ACCUM) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign accept    = in_valid && in_ready;

  // First beat of a frame loads rather than adds, so a
  // stale acc from the previous frame never leaks in.
  assign nxt = (cnt_q == '0) ? ACC_W'(in_prod)
             : acc_q + ACC_W'(in_prod);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    unique case (state_q)
      ACCUM: begin
        // acc only updates on accept, so X on an idle
        // in_prod cannot reach the register.
        if (accept) begin
          if (cnt_q == LAST) begin
            sum_d   = nxt;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            acc_d = nxt;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = ACCUM;
      end
    endcase
`ifdef ACC_CLEAR_EN
    // Abort wins over any beat taken this cycle;
    // the last published sum stays visible.
    if (clr) begin
      state_d = ACCUM;
      cnt_d   = '0;
      acc_d   = '0;
      sum_d   = sum_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator fed by Multiplier.
// Define ACC_CLEAR_EN to also exercise the clr abort.
module tb_product_accumulator;

  logic        clk;
  logic        rst;
  logic [3:0]  ma;
  logic [5:0]  mb;
  logic [9:0]  prod;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] out_sum;
  logic        out_valid;
  logic        out_ready;
`ifdef ACC_CLEAR_EN
  logic        clr;
`endif

  int n_vec = 0;
  int n_err = 0;

  Multiplier #(.WIDTH_A(4), .WIDTH_B(6)) u_mul (
    .a   (ma),
    .b   (mb),
    .out (prod)
  );

  product_accumulator #(
    .WIDTH_A(4), .WIDTH_B(6), .COUNT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ACC_CLEAR_EN
    .clr       (clr),
`endif
    .in_prod   (prod),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted beat; caller guarantees ACCUM state.
  task automatic beat(input int a, input int b);
    ma = 4'(a);
    mb = 6'(b);
    in_valid = 1'b1;
    #1;
    check("beat_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic frame86();
    beat(3, 5);
    beat(7, 9);
    beat(2, 4);
    beat(0, 63);
  endtask

  initial begin
    int pat [7];
    int k;
    pat = '{1, 0, 0, 1, 1, 0, 1};
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    ma = '0;
    mb = '0;
`ifdef ACC_CLEAR_EN
    clr = 1'b0;
`endif

    // reset state
    step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {20'd0, out_sum}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // 1: basic frame, 15+63+8+0
    frame86();
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_sum", {20'd0, out_sum}, 32'd86);
    check("t1_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("t1_valid_drop", {31'd0, out_valid}, 32'd0);
    check("t1_ready_back", {31'd0, in_ready}, 32'd1);

    // 2: max frame, 4*945
    for (int i = 0; i < 4; i++) beat(15, 63);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_sum", {20'd0, out_sum}, 32'd3780);
    step();

    // 3: backpressure
    out_ready = 1'b0;
    frame86();
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t3_hold_sum", {20'd0, out_sum}, 32'd86);
      check("t3_hold_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("t3_release_valid", {31'd0, out_valid}, 32'd0);
    check("t3_release_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) beat(1, 1);
    check("t3_fresh_sum", {20'd0, out_sum}, 32'd4);
    step();

    // 4: gapped input, idle beats carry X operands
    k = 1;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i][0];
      if (pat[i] == 1) begin
        ma = 4'd1;
        mb = 6'(k);
        k++;
      end else begin
        ma = 'x;
        mb = 'x;
      end
      step();
    end
    in_valid = 1'b0;
    ma = '0;
    mb = '0;
    check("t4_valid", {31'd0, out_valid}, 32'd1);
    check("t4_sum", {20'd0, out_sum}, 32'd10);
    step();

    // 5: reset mid-frame
    beat(3, 5);
    beat(7, 9);
    rst = 1'b1;
    in_valid = 1'b1;
    ma = 4'd1;
    mb = 6'd1;
    #1;
    check("t5_rst_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("t5_after_rst_sum", {20'd0, out_sum}, 32'd0);
    for (int i = 0; i < 4; i++) beat(1, 1);
    check("t5_valid", {31'd0, out_valid}, 32'd1);
    check("t5_sum", {20'd0, out_sum}, 32'd4);
    step();

    // reset while a sum is pending
    out_ready = 1'b0;
    frame86();
    check("t5b_pending", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    check("t5b_drop", {31'd0, out_valid}, 32'd0);
    #1;
    check("t5b_ready", {31'd0, in_ready}, 32'd1);

`ifdef ACC_CLEAR_EN
    // 6: clr aborts a partial frame and discards its beat
    for (int i = 0; i < 4; i++) beat(1, 1);
    step();
    beat(2, 5);
    beat(4, 5);
    clr = 1'b1;
    in_valid = 1'b1;
    ma = 4'd5;
    mb = 6'd6;
    step();
    clr = 1'b0;
    in_valid = 1'b0;
    check("t6_clr_valid", {31'd0, out_valid}, 32'd0);
    check("t6_clr_ready", {31'd0, in_ready}, 32'd1);
    check("t6_clr_sum_kept", {20'd0, out_sum}, 32'd4);
    beat(1, 1);
    beat(1, 2);
    beat(1, 3);
    beat(1, 4);
    check("t6_valid", {31'd0, out_valid}, 32'd1);
    check("t6_sum", {20'd0, out_sum}, 32'd10);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
